// File: rtl/add8_chain_scheduler_if.sv
// Bundle of the request, response and external-adder signals of the
// shared 8-bit adder scheduler. The slave side is the scheduler; the
// master side is the requester cluster together with the adder itself.
interface add8_chain_scheduler_if #(
  parameter int WORDS = 4,
  parameter int NREQ  = 2
);
  localparam int W   = 8 * WORDS;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // request channel
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  // external combinational adder
  logic [7:0]        add_i0;
  logic [7:0]        add_i1;
  logic              add_cin;
  logic [7:0]        add_o;
  logic              add_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready, add_o, add_cout,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy,
           add_i0, add_i1, add_cin
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready, add_o, add_cout,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy,
           add_i0, add_i1, add_cin
  );
endinterface

// File: rtl/add8_chain_scheduler.sv
// Time-shares one external 8-bit carry-chain adder among NREQ requesters.
// A granted request is added serially, one byte per cycle, LSB byte first,
// with the inter-byte carry kept in a register. Round-robin arbitration,
// one operation in flight, result held until the consumer takes it.
module add8_chain_scheduler #(
  parameter int WORDS = 4,
  parameter int NREQ  = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  add8_chain_scheduler_if.slave bus
);
  localparam int W   = 8 * WORDS;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IXW-1:0] idx_reg, idx_next;
  logic           carry_reg, carry_next;
  logic [W-1:0]   sum_reg, sum_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [IDW-1:0] id_reg, id_next;

  logic [IDW-1:0] cand [NREQ];
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [NREQ-1:0] ready_vec;

  // Candidate search order: ptr, ptr+1, ... wrapping modulo NREQ
  // (NREQ need not be a power of two, so wrap explicitly).
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] pos_wide;
    assign pos_wide = {1'b0, ptr_reg} + (IDW+1)'(gi);
    assign cand[gi] = (pos_wide >= (IDW+1)'(NREQ)) ?
                      IDW'(pos_wide - (IDW+1)'(NREQ)) : pos_wide[IDW-1:0];
  end

  // Round-robin pick: first valid requester in search order.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_valid && bus.req_valid[cand[k]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[k];
      end
    end
  end

  // One-hot accept, only while idle; forced low while reset is asserted
  // so that every output reads zero during reset.
  always_comb begin
    ready_vec = '0;
    if (rst_n && state_reg == ST_IDLE && grant_valid) begin
      ready_vec[grant_id] = 1'b1;
    end
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    sum_next   = sum_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    id_next    = id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          a_next     = bus.req_a[grant_id*W +: W];
          b_next     = bus.req_b[grant_id*W +: W];
          carry_next = bus.req_cin[grant_id];
          id_next    = grant_id;
          idx_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_next[8*idx_reg +: 8] = bus.add_o;
        carry_next               = bus.add_cout;
        if (idx_reg == IXW'(WORDS-1)) begin
          idx_next   = '0;
          state_next = ST_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
          ptr_next   = (id_reg == IDW'(NREQ-1)) ? '0 : id_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      sum_reg   <= sum_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      id_reg    <= id_next;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = (state_reg == ST_DONE);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = carry_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.add_i0    = (state_reg == ST_RUN) ? a_reg[8*idx_reg +: 8] : 8'h00;
  assign bus.add_i1    = (state_reg == ST_RUN) ? b_reg[8*idx_reg +: 8] : 8'h00;
  assign bus.add_cin   = (state_reg == ST_RUN) ? carry_reg : 1'b0;

endmodule

// File: tb/tb_add8_chain_scheduler.sv
// Self-checking bench for add8_chain_scheduler (WORDS=4, NREQ=2).
// Directed cases plus randomized transactions checked against a
// whole-word arithmetic model and a round-robin pointer model.
module tb_add8_chain_scheduler;
  localparam int WORDS = 4;
  localparam int NREQ  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   ptr_m;
  int   grants [$];
  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  logic        op_c [NREQ];

  add8_chain_scheduler_if #(.WORDS(WORDS), .NREQ(NREQ)) bus ();

  add8_chain_scheduler #(.WORDS(WORDS), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // external combinational 8-bit adder
  assign {bus.add_cout, bus.add_o} = 9'(bus.add_i0) + 9'(bus.add_i1) + 9'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_sum"},   64'(bus.rsp_sum),   64'd0);
    check({tag, "_rsp_cout"},  64'(bus.rsp_cout),  64'd0);
    check({tag, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_add_in"},    64'({bus.add_i0, bus.add_i1, bus.add_cin}), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: grant, serial RUN, optional stall in DONE, consume.
  task automatic txn(input logic [NREQ-1:0] mask, input int stall, input bit early_ready);
    int          w;
    logic [31:0] a, b;
    logic        c;
    logic [32:0] full, m, part;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int r;
      r = (ptr_m + k) % NREQ;
      if (w < 0 && mask[r]) w = r;
    end
    a = op_a[w];
    b = op_b[w];
    c = op_c[w];
    full = 33'(a) + 33'(b) + 33'(c);

    bus.req_a     = {op_a[1], op_a[0]};
    bus.req_b     = {op_b[1], op_b[0]};
    bus.req_cin   = {op_c[1], op_c[0]};
    bus.req_valid = mask;
    bus.rsp_ready = 1'b0;
    #1;
    check("grant_onehot", 64'(bus.req_ready), 64'd1 << w);
    check("grant_idle_busy", 64'(bus.busy), 64'd0);
    grants.push_back(w);
    tick();  // edge E0
    // operands must have been captured at E0; scramble them now
    bus.req_valid = mask & ~(NREQ'(1) << w);
    bus.req_a     = {$urandom(), $urandom()};
    bus.req_b     = {$urandom(), $urandom()};
    if (early_ready) bus.rsp_ready = 1'b1;
    for (int k = 0; k < WORDS; k++) begin
      m    = (33'd1 << (8*k)) - 33'd1;
      part = (33'(a) & m) + (33'(b) & m) + 33'(c);
      check("run_i0",    64'(bus.add_i0),    64'(a[8*k +: 8]));
      check("run_i1",    64'(bus.add_i1),    64'(b[8*k +: 8]));
      check("run_cin",   64'(bus.add_cin),   64'(part[8*k]));
      check("run_nrsp",  64'(bus.rsp_valid), 64'd0);
      check("run_nrdy",  64'(bus.req_ready), 64'd0);
      tick();
    end
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rsp_sum",   64'(bus.rsp_sum),   64'(full[31:0]));
    check("rsp_cout",  64'(bus.rsp_cout),  64'(full[32]));
    check("rsp_id",    64'(bus.rsp_id),    64'(w));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_sum",   64'(bus.rsp_sum),   64'(full[31:0]));
      check("hold_cout",  64'(bus.rsp_cout),  64'(full[32]));
      check("hold_id",    64'(bus.rsp_id),    64'(w));
      check("hold_busy",  64'(bus.busy),      64'd1);
      check("hold_nrdy",  64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("consumed_nrsp", 64'(bus.rsp_valid), 64'd0);
    check("consumed_idle", 64'(bus.busy),      64'd0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    ptr_m = (w + 1) % NREQ;
    $display("txn id=%0d a=%08h b=%08h cin=%0d sum=%08h cout=%0d stall=%0d",
             w, a, b, c, full[31:0], full[32], stall);
  endtask

  initial begin
    logic [3:0] order;
    checks = 0;
    errors = 0;
    ptr_m  = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;

    // reset state
    #3;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // both requesters contending from reset: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        op_a[r] = $urandom();
        op_b[r] = $urandom();
        op_c[r] = 1'($urandom_range(0, 1));
      end
      txn(2'b11, 0, 1'b1);
    end
    for (int i = 0; i < 4; i++) order[i] = grants[i][0];
    check("rr_order", 64'(order), 64'b1010);

    // directed carry cases
    op_a[0] = 32'h000000FF; op_b[0] = 32'h00000001; op_c[0] = 1'b0;
    txn(2'b01, 0, 1'b0);
    check("case1_sum", 64'(bus.rsp_sum), 64'h00000100);
    op_a[1] = 32'hFFFFFFFF; op_b[1] = 32'h00000000; op_c[1] = 1'b1;
    txn(2'b10, 0, 1'b0);
    check("case2_cout", 64'(bus.rsp_cout), 64'd1);
    op_a[0] = 32'h80808080; op_b[0] = 32'h80808080; op_c[0] = 1'b0;
    txn(2'b01, 0, 1'b0);
    check("case3_sum", 64'(bus.rsp_sum), 64'h01010100);

    // response stalled 3 cycles, other requester waiting meanwhile
    op_a[1] = $urandom(); op_b[1] = $urandom(); op_c[1] = 1'b0;
    op_a[0] = $urandom(); op_b[0] = $urandom(); op_c[0] = 1'b1;
    txn(2'b11, 3, 1'b0);

    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      int st;
      for (int r = 0; r < NREQ; r++) begin
        op_a[r] = $urandom();
        op_b[r] = $urandom();
        op_c[r] = 1'($urandom_range(0, 1));
      end
      st = $urandom_range(0, 2);
      txn(NREQ'($urandom_range(1, 3)), st, (st == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // make req0 the last served so the rr pointer sits at 1
    op_a[0] = $urandom(); op_b[0] = $urandom(); op_c[0] = 1'b0;
    txn(2'b01, 0, 1'b0);

    // abort a req1 operation at idx=2 with reset
    bus.req_a     = {$urandom(), $urandom()};
    bus.req_b     = {$urandom(), $urandom()};
    bus.req_valid = 2'b10;
    #1;
    check("abort_grant", 64'(bus.req_ready), 64'b10);
    tick();  // E0
    bus.req_valid = 2'b00;
    tick();
    tick();  // idx is now 2
    #2;
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    tick();
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    ptr_m = 0;
    for (int r = 0; r < NREQ; r++) begin
      op_a[r] = $urandom();
      op_b[r] = $urandom();
      op_c[r] = 1'($urandom_range(0, 1));
    end
    txn(2'b11, 0, 1'b0);
    check("abort_next_id", 64'(grants[grants.size()-1]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
